opsum_glb_writer: RTL
=====================

OPSUM_GLB_WRITER -- requirements
Module: opsum_glb_writer

Interface
REQ-001 SHALL have parameter NUM_COL, default 32, number of opsum FIFO columns.
REQ-002 SHALL have parameter DATA_W, default 16, opsum element width; GLB word is 2*DATA_W = 32 bits.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start_i  input  1  pulse; latch configuration and begin drain pass.
REQ-006 SHALL have port col_en_i  input  NUM_COL  columns to drain this pass.
REQ-007 SHALL have port opsum_base_addr_i  input  NUM_COL x 32  per-column GLB byte base address, 4-byte aligned.
REQ-008 SHALL have port elems_per_col_i  input  16  opsum elements to drain per enabled column.
REQ-009 SHALL have port opsum_fifo_empty_i  input  NUM_COL  per-column FIFO empty flag.
REQ-010 SHALL have port opsum_fifo_data_i  input  NUM_COL x DATA_W  per-column FIFO head (first-word-fall-through).
REQ-011 SHALL have port opsum_fifo_pop_o  output  NUM_COL  at most one bit high; consumes that column's head this cycle.
REQ-012 SHALL have ports glb_write_req_o (1), glb_write_addr_o (32), glb_write_data_o (32), glb_write_web_o (4, active-low byte enables)  outputs  GLB write request.
REQ-013 SHALL have port glb_write_permit_i  input  1  grant from token arbiter; write completes in the cycle req and permit are both high.
REQ-014 SHALL have ports busy_o (1) and done_o (1, single-cycle pulse)  outputs.

Function
REQ-015 SHALL implement FSM IDLE, SELECT, POP_LO, POP_HI, WRITE, DONE.
REQ-016 IDLE: on start_i latch col_en_i, base addresses, remaining[c] = elems_per_col_i for enabled columns (0 otherwise), elem_idx[c] = 0, rr_ptr = 0; go SELECT; busy_o high from next cycle until DONE exits.
REQ-017 start_i outside IDLE SHALL be ignored.
REQ-018 SELECT: eligible column = remaining>0 and FIFO not empty; pick first eligible at or after rr_ptr (wrapping); go POP_LO; none eligible but any remaining>0 -> stay; all remaining==0 -> DONE.
REQ-019 POP_LO: assert pop for selected column one cycle, capture head into data[15:0]; go POP_HI if packing applies (REQ-031) and remaining>=2, else WRITE.
REQ-020 POP_HI: if selected FIFO non-empty, pop one cycle, capture head into data[31:16], go WRITE; if empty, wait in POP_HI with pop low.
REQ-021 WRITE: req high; addr = base[c] + 2*elem_idx[c] (32-bit wrap); web = 4'b0000 for two elements, 4'b1100 for one (upper half data zero); addr/data/web stable while req high without permit.
REQ-022 On permit: remaining[c] and elem_idx[c] adjust by elements written (1 or 2); rr_ptr = c+1 mod NUM_COL; go SELECT.
REQ-023 DONE: done_o high exactly one cycle, busy_o low, go IDLE.
REQ-024 start_i with no enabled column or elems_per_col_i==0 SHALL give done_o two cycles after start_i, with no pop or write.
REQ-025 Pop-to-request latency: pop in POP_LO at cycle t -> req at t+1 (single) or t+2 (pair, FIFO non-empty).
REQ-026 glb_write_req_o SHALL never be high outside WRITE; opsum_fifo_pop_o SHALL never pop an empty FIFO.

Reset
REQ-027 rst SHALL force state IDLE and all outputs low (pop, req, addr, data, busy_o, done_o = 0; web = 4'hF).
REQ-028 rst SHALL clear remaining, elem_idx, rr_ptr and holding register.
REQ-029 rst mid-pass SHALL abandon any pending write without completing it; no done_o.
REQ-030 rst has priority over start_i in the same cycle.

Configuration
REQ-031 Macro OPSUM_WR_PACK_EN defined: two consecutive elements of one column packed per write (REQ-019/020), single-element write only for an odd final element.
REQ-032 OPSUM_WR_PACK_EN undefined: POP_HI unused; every write carries one element, web = 4'b1100, addr = base + 2*elem_idx.

Verification
REQ-033 Pack on, col 0 only, elems=4, base 0x100, FIFO preloaded 1,2,3,4, permit tied 1 -> writes (0x100, 0x00020001, web 0) then (0x104, 0x00040003, web 0), then done_o pulse.
REQ-034 Pack on, elems=3, col 5, base 0x200 -> writes 0x200 pair, then 0x204 data 0x0000_xxxx low half, web 4'b1100; remaining 0.
REQ-035 Cols 0,1,2 enabled, elems=2, all FIFOs full -> service order 0,1,2; col 1 empty at its turn -> order 0,2,1 once it refills.
REQ-036 Permit held low 5 cycles in WRITE -> req, addr, data, web unchanged all 5 cycles; completes cycle permit rises.
REQ-037 Col 0 FIFO empties after first pop (elems=2, pack on) -> FSM waits in POP_HI, no pop; pushes 7 -> pops, writes high half 7.
REQ-038 rst asserted while req high without permit -> next cycle req=0, busy_o=0, state IDLE; no done_o.

Source files
------------

// File: rtl/opsum_glb_writer_if.sv
// Opsum FIFO read side and GLB write request bundle for opsum_glb_writer.
// master = writer (pops FIFOs, issues writes); slave = FIFO bank / GLB arbiter side.
interface opsum_glb_writer_if #(
  parameter int NUM_COL = 32,
  parameter int DATA_W  = 16
);
  logic [NUM_COL-1:0]             opsum_fifo_empty_i;
  logic [NUM_COL-1:0][DATA_W-1:0] opsum_fifo_data_i;
  logic [NUM_COL-1:0]             opsum_fifo_pop_o;
  logic                           glb_write_req_o;
  logic [31:0]                    glb_write_addr_o;
  logic [2*DATA_W-1:0]            glb_write_data_o;
  logic [3:0]                     glb_write_web_o;
  logic                           glb_write_permit_i;

  modport master (
    input  opsum_fifo_empty_i, opsum_fifo_data_i, glb_write_permit_i,
    output opsum_fifo_pop_o, glb_write_req_o, glb_write_addr_o,
           glb_write_data_o, glb_write_web_o
  );

  modport slave (
    output opsum_fifo_empty_i, opsum_fifo_data_i, glb_write_permit_i,
    input  opsum_fifo_pop_o, glb_write_req_o, glb_write_addr_o,
           glb_write_data_o, glb_write_web_o
  );
endinterface

// File: rtl/opsum_glb_writer.sv
// Drains per-column opsum FIFOs round-robin into GLB word writes.
// Define OPSUM_WR_PACK_EN to pack two consecutive elements of a column per write.
module opsum_glb_writer #(
  parameter int NUM_COL = 32,
  parameter int DATA_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [NUM_COL-1:0]        col_en_i,
  input  logic [NUM_COL-1:0][31:0]  opsum_base_addr_i,
  input  logic [15:0]               elems_per_col_i,
  opsum_glb_writer_if.master        bus,
  output logic                      busy_o,
  output logic                      done_o
);
  localparam int CW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
  localparam int WW = 2 * DATA_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_POP_LO = 3'd2;
  localparam logic [2:0] S_POP_HI = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]                 state_q, state_d;
  logic [NUM_COL-1:0][31:0]   base_q, base_d;
  logic [NUM_COL-1:0][15:0]   remaining_q, remaining_d;
  logic [NUM_COL-1:0][15:0]   elem_idx_q, elem_idx_d;
  logic [CW-1:0]              rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]              sel_q, sel_d;
  logic [31:0]                addr_q, addr_d;
  logic [WW-1:0]              data_q, data_d;
  logic                       pair_q, pair_d;

  logic [NUM_COL-1:0]         rem_nz;
  logic [NUM_COL-1:0]         eligible;
  logic [NUM_COL-1:0]         pop;
  logic                       found;
  logic [CW-1:0]              pick;
  logic [CW:0]                idx_sum;
  logic [15:0]                step_n;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COL; gi++) begin : g_col
      assign rem_nz[gi]   = (remaining_q[gi] != 16'd0);
      assign eligible[gi] = rem_nz[gi] & ~bus.opsum_fifo_empty_i[gi];
    end
  endgenerate

  // First eligible column at or after rr_ptr, wrapping past NUM_COL-1.
  always_comb begin
    found   = 1'b0;
    pick    = '0;
    idx_sum = '0;
    for (int k = 0; k < NUM_COL; k++) begin
      idx_sum = {1'b0, rr_ptr_q} + (CW+1)'(k);
      if (idx_sum >= (CW+1)'(NUM_COL)) idx_sum = idx_sum - (CW+1)'(NUM_COL);
      if (!found && eligible[idx_sum[CW-1:0]]) begin
        found = 1'b1;
        pick  = idx_sum[CW-1:0];
      end
    end
  end

  assign step_n = pair_q ? 16'd2 : 16'd1;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    remaining_d = remaining_q;
    elem_idx_d  = elem_idx_q;
    rr_ptr_d    = rr_ptr_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    data_d      = data_q;
    pair_d      = pair_q;
    pop         = '0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          base_d = opsum_base_addr_i;
          for (int c = 0; c < NUM_COL; c++) begin
            remaining_d[c] = col_en_i[c] ? elems_per_col_i : 16'd0;
            elem_idx_d[c]  = 16'd0;
          end
          rr_ptr_d = '0;
          state_d  = S_SELECT;
        end
      end
      S_SELECT: begin
        if (found) begin
          sel_d   = pick;
          addr_d  = base_q[pick] + {15'd0, elem_idx_q[pick], 1'b0};
          state_d = S_POP_LO;
        end else if (rem_nz == '0) begin
          state_d = S_DONE;
        end
      end
      S_POP_LO: begin
        // SELECT only enters here with a non-empty FIFO, so the pop is safe.
        pop[sel_q] = 1'b1;
        data_d     = {{DATA_W{1'b0}}, bus.opsum_fifo_data_i[sel_q]};
`ifdef OPSUM_WR_PACK_EN
        pair_d     = (remaining_q[sel_q] >= 16'd2);
        state_d    = pair_d ? S_POP_HI : S_WRITE;
`else
        pair_d     = 1'b0;
        state_d    = S_WRITE;
`endif
      end
      S_POP_HI: begin
        if (!bus.opsum_fifo_empty_i[sel_q]) begin
          pop[sel_q]           = 1'b1;
          data_d[WW-1:DATA_W]  = bus.opsum_fifo_data_i[sel_q];
          state_d              = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.glb_write_permit_i) begin
          remaining_d[sel_q] = remaining_q[sel_q] - step_n;
          elem_idx_d[sel_q]  = elem_idx_q[sel_q] + step_n;
          rr_ptr_d           = (sel_q == CW'(NUM_COL - 1)) ? '0 : sel_q + 1'b1;
          state_d            = S_SELECT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      remaining_q <= '0;
      elem_idx_q  <= '0;
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      pair_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      remaining_q <= remaining_d;
      elem_idx_q  <= elem_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      pair_q      <= pair_d;
    end
  end

  // Address and data are registered before WRITE, so they hold steady while permit is low.
  assign bus.opsum_fifo_pop_o = pop;
  assign bus.glb_write_req_o  = (state_q == S_WRITE);
  assign bus.glb_write_addr_o = addr_q;
  assign bus.glb_write_data_o = data_q;
  assign bus.glb_write_web_o  = (state_q == S_WRITE) ? (pair_q ? 4'b0000 : 4'b1100) : 4'hF;
  assign busy_o = (state_q == S_SELECT) || (state_q == S_POP_LO) ||
                  (state_q == S_POP_HI) || (state_q == S_WRITE);
  assign done_o = (state_q == S_DONE);
endmodule
